// File: rtl/data_mem_wr_ctrl_nbuf_if.sv
// Video input and memory-write bus for the ring-buffer frame writer.
// master = the write controller, slave = the video source / memory side.
interface data_mem_wr_ctrl_nbuf_if #(
  parameter int ADDRS_DW = 21,
  parameter int DW       = 16
);
  logic [DW-1:0]       data;
  logic                hs;
  logic                vs;
  logic                mem_wr_busy;
  logic                mem_wr_start;
  logic [ADDRS_DW-1:0] mem_wr_addrs;
  logic [ADDRS_DW-1:0] mem_wr_lengths;
  logic [DW-1:0]       mem_wr_data;
  logic                mem_wr_data_vld;

  modport master (
    input  data, hs, vs, mem_wr_busy,
    output mem_wr_start, mem_wr_addrs, mem_wr_lengths, mem_wr_data, mem_wr_data_vld
  );

  modport slave (
    output data, hs, vs, mem_wr_busy,
    input  mem_wr_start, mem_wr_addrs, mem_wr_lengths, mem_wr_data, mem_wr_data_vld
  );
endinterface

// File: rtl/data_mem_wr_ctrl_nbuf.sv
// Frame writer into BUF_NUM ring buffers (base + idx*stride) with pixel-count
// integrity check, busy-skip, freeze, and a last-good-buffer read index.
module data_mem_wr_ctrl_nbuf #(
  parameter int IMAGE_WIDE_LENGTH = 256,
  parameter int IMAGE_HIGH_LENGTH = 192,
  parameter int ADDRS_DW          = 21,
  parameter int DW                = 16,
  parameter int BUF_NUM           = 3,
  localparam int IDX_W            = (BUF_NUM <= 2) ? 1 : $clog2(BUF_NUM),
  localparam int PIX_NUM          = IMAGE_WIDE_LENGTH * IMAGE_HIGH_LENGTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_freeze_en,
  input  logic [ADDRS_DW-1:0] i_base_addrs,
  input  logic [ADDRS_DW-1:0] i_buf_stride,
  data_mem_wr_ctrl_nbuf_if.master io_bus,
  output logic [IDX_W-1:0]    o_wr_idx,
  output logic [IDX_W-1:0]    o_rd_idx,
  output logic                o_rd_vld,
  output logic                o_frame_done,
  output logic                o_frame_err,
  output logic                o_frame_skip
);
  localparam int CNT_W = $clog2(PIX_NUM + 1);
  localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(PIX_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP, S_CHECK} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_vs_d;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic [IDX_W-1:0]    r_wr_idx, r_rd_idx;
  logic                r_rd_vld, r_done, r_err, r_skip, r_start, r_vld;
  logic [ADDRS_DW-1:0] r_addrs;
  logic [DW-1:0]       r_data;

  logic w_rise, w_fall, w_pix_in, w_good, w_addr_unused;
  logic w_start, w_skip, w_vld, w_over, w_done, w_err, w_clr;
  logic [ADDRS_DW-1:0] w_addr;

  assign w_rise   = io_bus.vs & ~r_vs_d;
  assign w_fall   = ~io_bus.vs & r_vs_d;
  assign w_pix_in = io_bus.hs & io_bus.vs;
  assign w_good   = (r_cnt == PIX_MAX) & ~r_ovf;
  assign w_addr   = i_base_addrs + ADDRS_DW'(r_wr_idx) * i_buf_stride;
  assign w_addr_unused = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_nxt = (i_freeze_en | io_bus.mem_wr_busy) ? S_DROP : S_WRITE;
      S_WRITE: if (w_fall) w_state_nxt = S_CHECK;
      S_DROP:  if (w_fall) w_state_nxt = S_IDLE;
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_skip  = 1'b0;
    w_vld   = 1'b0;
    w_over  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = w_rise & ~i_freeze_en & ~io_bus.mem_wr_busy;
        w_skip  = w_rise & ~i_freeze_en & io_bus.mem_wr_busy;
      end
      S_WRITE: begin
        w_vld  = w_pix_in & (r_cnt < PIX_MAX);
        w_over = w_pix_in & (r_cnt == PIX_MAX);
      end
      S_CHECK: begin
        w_done = w_good;
        w_err  = ~w_good;
        w_clr  = 1'b1;
      end
      default: ;
    endcase
  end

  // vs_d resets high so a frame already running at reset release never looks like a rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_d   <= 1'b1;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_rd_vld <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_skip   <= 1'b0;
      r_start  <= 1'b0;
      r_vld    <= 1'b0;
      r_addrs  <= '0;
      r_data   <= '0;
    end else begin
      r_vs_d  <= io_bus.vs;
      r_done  <= w_done;
      r_err   <= w_err;
      r_skip  <= w_skip;
      r_start <= w_start;
      r_vld   <= w_vld;
      r_data  <= w_vld ? io_bus.data : '0;
      if (w_start) r_addrs <= w_addr;
      if (w_vld)   r_cnt   <= r_cnt + CNT_W'(1);
      if (w_over)  r_ovf   <= 1'b1;
      if (w_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
      if (w_done) begin
        r_rd_idx <= r_wr_idx;
        r_rd_vld <= 1'b1;
        r_wr_idx <= (r_wr_idx == IDX_LAST) ? '0 : r_wr_idx + IDX_W'(1);
      end
    end
  end

  assign io_bus.mem_wr_start    = r_start;
  assign io_bus.mem_wr_addrs    = r_addrs;
  assign io_bus.mem_wr_lengths  = ADDRS_DW'(PIX_NUM);
  assign io_bus.mem_wr_data     = r_data;
  assign io_bus.mem_wr_data_vld = r_vld;
  assign o_wr_idx     = r_wr_idx;
  assign o_rd_idx     = r_rd_idx;
  assign o_rd_vld     = r_rd_vld;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_err;
  assign o_frame_skip = r_skip;
endmodule

// File: tb/tb_data_mem_wr_ctrl_nbuf.sv
// Randomized frame-level bench: each frame's expected outcome is derived from
// frame length, freeze/busy at the rise, and a ring-index model.
module tb_data_mem_wr_ctrl_nbuf;
  localparam int W     = 16;
  localparam int H     = 12;
  localparam int ADW   = 21;
  localparam int DW    = 16;
  localparam int BN    = 3;
  localparam int PIX   = W * H;
  localparam int IDX_W = (BN <= 2) ? 1 : $clog2(BN);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             frz;
  logic [ADW-1:0]   base, stride;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             rd_vld, done, err, skip;

  data_mem_wr_ctrl_nbuf_if #(.ADDRS_DW(ADW), .DW(DW)) bus();

  data_mem_wr_ctrl_nbuf #(
    .IMAGE_WIDE_LENGTH(W), .IMAGE_HIGH_LENGTH(H),
    .ADDRS_DW(ADW), .DW(DW), .BUF_NUM(BN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_freeze_en(frz),
    .i_base_addrs(base), .i_buf_stride(stride),
    .io_bus(bus),
    .o_wr_idx(wr_idx), .o_rd_idx(rd_idx), .o_rd_vld(rd_vld),
    .o_frame_done(done), .o_frame_err(err), .o_frame_skip(skip)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: ring write slot, last good slot
  int m_wr = 0;
  int m_rd = 0;
  bit m_rd_vld = 1'b0;

  logic [DW-1:0]  q_got[$];
  logic [DW-1:0]  q_exp[$];
  int             n_start = 0, n_done = 0, n_err = 0, n_skip = 0, start_q = 0;
  logic [ADW-1:0] got_addr = '0;

  always @(negedge clk) begin
    if (bus.mem_wr_start === 1'b1) begin
      n_start++;
      got_addr = bus.mem_wr_addrs;
      start_q  = q_got.size();
    end
    if (bus.mem_wr_data_vld === 1'b1) q_got.push_back(bus.mem_wr_data);
    if (done === 1'b1) n_done++;
    if (err  === 1'b1) n_err++;
    if (skip === 1'b1) n_skip++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({wr_idx, rd_idx, rd_vld, done, err, skip, bus.mem_wr_start,
                bus.mem_wr_addrs, bus.mem_wr_data, bus.mem_wr_data_vld});
  endfunction

  task automatic check_idx();
    chk("wr_idx", 64'(wr_idx), 64'(m_wr));
    chk("rd_idx", 64'(rd_idx), 64'(m_rd));
    chk("rd_vld", 64'(rd_vld), 64'(m_rd_vld));
  endtask

  task automatic run_frame(input int lines, input bit f, input bit busy, input int rst_pix,
                           input logic [ADW-1:0] b, input logic [ADW-1:0] s);
    int sent = 0;
    int s0 = n_start, d0 = n_done, e0 = n_err, k0 = n_skip, q0 = q_got.size();
    int exp_n, mism;
    bit started, good;
    logic [ADW-1:0] exp_addr;
    exp_addr = ADW'(64'(b) + 64'(m_wr) * 64'(s));
    q_exp.delete();
    @(negedge clk);
    bus.vs = 1'b1; frz = f; bus.mem_wr_busy = busy; base = b; stride = s;
    @(negedge clk);
    frz = 1'($urandom); bus.mem_wr_busy = 1'($urandom);
    base = ADW'($urandom); stride = ADW'($urandom);
    repeat ($urandom_range(2, 3)) @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < W; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.hs = 1'b0;
          @(negedge clk);
        end
        bus.hs = 1'b1;
        bus.data = DW'($urandom);
        if (sent == rst_pix) rst = 1'b1;
        else if (sent < PIX) q_exp.push_back(bus.data);
        sent++;
        @(negedge clk);
        if (rst) begin
          rst = 1'b0;
          chk("rst_mid_outs", all_outs(), 64'd0);
        end
      end
      bus.hs = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.vs = 1'b0; bus.hs = 1'b0;
    repeat (4) @(negedge clk);

    if (rst_pix >= 0) begin
      m_wr = 0; m_rd = 0; m_rd_vld = 1'b0;
      chk("rst_no_done", 64'(n_done - d0), 64'd0);
      chk("rst_no_err",  64'(n_err - e0),  64'd0);
      check_idx();
      return;
    end

    started = !f && !busy;
    good    = started && (sent == PIX);
    exp_n   = started ? q_exp.size() : 0;
    chk("start_cnt", 64'(n_start - s0), 64'(started));
    if (started) begin
      chk("start_addr", 64'(got_addr), 64'(exp_addr));
      chk("vld_after_start", 64'(start_q), 64'(q0));
      mism = 0;
      for (int i = 0; i < exp_n && q0 + i < q_got.size(); i++)
        if (q_got[q0 + i] !== q_exp[i]) mism++;
      chk("pix_data", 64'(mism), 64'd0);
    end
    chk("vld_cnt", 64'(q_got.size() - q0), 64'(exp_n));
    chk("skip_cnt", 64'(n_skip - k0), 64'(!f && busy));
    chk("done_cnt", 64'(n_done - d0), 64'(good));
    chk("err_cnt",  64'(n_err - e0),  64'(started && !good));
    if (good) begin
      m_rd = m_wr;
      m_rd_vld = 1'b1;
      m_wr = (m_wr + 1) % BN;
    end
    check_idx();
  endtask

  initial begin
    int s0, q0, d0, e0, k0;
    rst = 1'b1; frz = 1'b0; base = '0; stride = '0;
    bus.vs = 1'b1; bus.hs = 1'b0; bus.data = '0; bus.mem_wr_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);

    // release reset in the middle of a frame: it must be ignored entirely
    s0 = n_start; q0 = q_got.size(); d0 = n_done; e0 = n_err; k0 = n_skip;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.hs = 1'b1; bus.data = DW'($urandom);
      @(negedge clk);
    end
    bus.hs = 1'b0; bus.vs = 1'b0;
    repeat (4) @(negedge clk);
    chk("partial_start", 64'(n_start - s0), 64'd0);
    chk("partial_vld", 64'(q_got.size() - q0), 64'd0);
    chk("partial_pulses", 64'((n_done - d0) + (n_err - e0) + (n_skip - k0)), 64'd0);
    check_idx();

    // four good frames: wrap through the ring
    for (int i = 0; i < 4; i++) run_frame(H, 1'b0, 1'b0, -1, 21'h1000, 21'hC000);
    // freeze, then the same slot is written by the next frame
    run_frame(H, 1'b1, 1'b0, -1, 21'h1000, 21'hC000);
    run_frame(H, 1'b0, 1'b0, -1, 21'h1000, 21'hC000);
    // memory busy at the rise
    run_frame(H, 1'b0, 1'b1, -1, 21'h1000, 21'hC000);
    // short and long frames
    run_frame(H - 1, 1'b0, 1'b0, -1, 21'h1000, 21'hC000);
    run_frame(H + 1, 1'b0, 1'b0, -1, 21'h1000, 21'hC000);
    // reset mid-frame, then the next frame goes to buffer 0
    run_frame(H, 1'b0, 1'b0, 50, 21'h1000, 21'hC000);
    run_frame(H, 1'b0, 1'b0, -1, 21'h1000, 21'hC000);
    // randomized mix, including address wrap past 2^ADW
    for (int i = 0; i < 8; i++) begin
      int lines;
      case ($urandom_range(0, 5))
        0:       lines = H - 1;
        1:       lines = H + 1;
        default: lines = H;
      endcase
      run_frame(lines, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), -1,
                ADW'($urandom), ADW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
